// File: rtl/nibble_descrambler_rx.sv
// Purpose: receive side of the 4-bit NOR/XOR nibble scrambler; shifts in 4 scrambled bits + odd parity, decodes, registers.
// Latency: data/valid appear 1 clock after the edge that samples the parity bit.
// Backpressure: none; sen gates each serial bit, sync drops a partial frame, the receiver never stalls the sender.
//
// Ports (8-in/8-out user-module slot):
//   io_in[0] clk, io_in[1] rst_n (async, active-low), io_in[2] sdata (y3 first, parity last),
//   io_in[3] sen, io_in[4] bypass, io_in[5] sync, io_in[7:6] unused.
//   io_out[3:0] data, io_out[4] valid, io_out[5] perr, io_out[6] busy, io_out[7] ftog.
module nibble_descrambler_rx (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic clk;
  logic rst_n;
  logic sdata;
  logic sen;
  logic bypass;
  logic sync;
  logic unused_pins;

  assign clk         = io_in[0];
  assign rst_n       = io_in[1];
  assign sdata       = io_in[2];
  assign sen         = io_in[3];
  assign bypass      = io_in[4];
  assign sync        = io_in[5];
  assign unused_pins = ^io_in[7:6];

  logic [2:0] cnt;
  logic [3:0] sr;
  logic [3:0] data;
  logic       valid;
  logic       perr;
  logic       ftog;

  // Inverse scramble. Each recovered bit feeds the next stage, so the
  // evaluation order a1 -> a2 -> a3 -> a0 matters.
  logic a0, a1, a2, a3;
  logic [3:0] plain;

  always_comb begin
    a1    = sr[0] ^ ~(sr[3] | sr[2]);
    a2    = sr[1] ^ ~(a1 | sr[3]);
    a3    = sr[2] ^ ~(a2 | a1);
    a0    = sr[3] ^ ~(a3 | a2);
    plain = {a3, a2, a1, a0};
  end

  // On the commit edge sdata carries the parity bit; a good frame has odd
  // weight over y3..y0 and p together.
  logic parity_bad;
  assign parity_bad = ~(^sr ^ sdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 3'd0;
      sr    <= 4'd0;
      data  <= 4'd0;
      valid <= 1'b0;
      perr  <= 1'b0;
      ftog  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (sync) begin
        // Drops any partial frame; wins over sen so no commit happens here.
        cnt <= 3'd0;
      end else if (sen) begin
        if (cnt != 3'd4) begin
          sr  <= {sr[2:0], sdata};
          cnt <= cnt + 3'd1;
        end else begin
          cnt   <= 3'd0;
          data  <= bypass ? sr : plain;
          perr  <= parity_bad;
          valid <= 1'b1;
          ftog  <= ~ftog;
        end
      end
    end
  end

  assign io_out = {ftog, (cnt != 3'd0), perr, valid, data};

endmodule

// File: tb/tb_nibble_descrambler_rx.sv
module tb_nibble_descrambler_rx;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       sdata  = 1'b0;
  logic       sen    = 1'b0;
  logic       bypass = 1'b0;
  logic       sync   = 1'b0;
  logic [1:0] spare  = 2'b00;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {spare, sync, bypass, sen, sdata, rst_n, clk};

  nibble_descrambler_rx dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected commit record: {ftog, busy, perr, data}
  logic [6:0] expq[$];
  logic       exp_ftog = 1'b0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, want);
    end
  endtask

  // Forward scrambler (transmit side), used to build exhaustive stimulus.
  function automatic logic [3:0] scramble(input logic [3:0] a);
    logic y3, y2, y1, y0;
    y3 = a[0] ^ ~(a[3] | a[2]);
    y2 = a[3] ^ ~(a[2] | a[1]);
    y1 = a[2] ^ ~(a[1] | y3);
    y0 = a[1] ^ ~(y3 | y2);
    return {y3, y2, y1, y0};
  endfunction

  task automatic drive_bit(input logic b, input logic byp);
    @(negedge clk);
    sdata  = b;
    sen    = 1'b1;
    bypass = byp;
    sync   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sen    = 1'b0;
      sync   = 1'b0;
      bypass = 1'b0;
      sdata  = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [3:0] y, input logic p, input logic byp,
                            input logic [3:0] edata, input logic eperr, input logic gaps);
    for (int i = 3; i >= 0; i--) begin
      drive_bit(y[i], byp);
      if (gaps) idle(1);
    end
    drive_bit(p, byp);
    exp_ftog = ~exp_ftog;
    expq.push_back({exp_ftog, 1'b0, eperr, edata});
    if (gaps) idle(1);
  endtask

  // Monitor: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && io_out[4]) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got io_out 0x%02h with no commit pending", io_out);
      end else begin
        logic [6:0] e;
        e = expq.pop_front();
        check("commit", {1'b0, io_out[7:5], io_out[3:0]}, {1'b0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;

    // Reset holds outputs at zero regardless of other inputs.
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      {spare, sync, bypass, sen, sdata} = 6'($urandom);
      #1 check("reset_out", io_out, 8'h00);
    end
    {spare, sync, bypass, sen, sdata} = 6'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-frame leaves no residue.
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    @(negedge clk);
    sen      = 1'b0;
    rst_n    = 1'b0;
    exp_ftog = 1'b0;
    #1 check("midframe_reset", io_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(4'hC, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    idle(2);

    // Back-to-back decode with sen held high.
    send_frame(4'hC, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    send_frame(4'hA, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
    send_frame(4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
    idle(2);

    // Parity error still commits; next good frame clears perr.
    send_frame(4'hA, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0);
    send_frame(4'hC, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    idle(2);

    // Bypass stores the raw scrambled nibble.
    send_frame(4'hA, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
    idle(2);

    // Sync drops a partial frame and suppresses commit.
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    @(negedge clk);
    sen   = 1'b1;
    sync  = 1'b1;
    sdata = 1'b1;
    @(negedge clk);
    sen  = 1'b0;
    sync = 1'b0;
    check("sync_busy", {7'd0, io_out[6]}, 8'h00);
    idle(2);

    // Gapped frame: valid exactly one cycle after the parity edge.
    send_frame(4'hC, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    check("gap_valid_hi", {7'd0, io_out[4]}, 8'h01);
    idle(1);
    check("gap_valid_lo", {7'd0, io_out[4]}, 8'h00);
    idle(2);

    // Exhaustive round trip from a fresh reset.
    @(negedge clk);
    rst_n    = 1'b0;
    exp_ftog = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int x = 0; x < 16; x++) begin
      logic [3:0] y;
      y = scramble(4'(x));
      send_frame(y, ~^y, 1'b0, 4'(x), 1'b0, 1'b0);
    end
    idle(2);
    check("ftog_after_16", {7'd0, io_out[7]}, 8'h00);

    waited = 0;
    while (expq.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d commits still pending expected 0", expq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
